// File: rtl/nn_test_data_loader.sv
// Writer side of the test-sample store: packs a byte stream MSB-first into
// 496-bit vectors, writes them to a 750-entry memory, and serves a zero-latency read port.
module nn_test_data_loader #(
    parameter int WORD_BYTES = 62,
    parameter int DEPTH      = 750,
    parameter int ADDR_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    load_busy,
    output logic                    loaded,
    output logic [ADDR_W-1:0]       wr_count,
    output logic [1:0]              dbg_state
);
    localparam int VEC_W = 8 * WORD_BYTES;
    localparam logic [5:0]        LAST_BYTE = 6'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_VEC  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready is a pure decode of the state register, never of in_valid.
    state_t                r_state;
    state_t                w_state_next;
    logic [5:0]            r_byte_cnt;
    logic [ADDR_W-1:0]     r_wr_count;
    logic [VEC_W-9:0]      r_pack;
    logic [VEC_W-1:0]      r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_start_load;
    logic [VEC_W-1:0]      w_packed;

    assign w_accept     = in_valid && (r_state == S_LOAD);
    assign w_last_byte  = (r_byte_cnt == LAST_BYTE);
    assign w_start_load = load_start && (r_state != S_LOAD);
    assign w_packed     = {r_pack, in_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (load_start) w_state_next = S_LOAD;
            S_LOAD: if (w_accept && w_last_byte && (r_wr_count == LAST_VEC)) w_state_next = S_DONE;
            S_DONE: if (load_start) w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_wr_count <= '0;
            r_pack     <= '0;
        end else if (w_start_load) begin
            r_byte_cnt <= '0;
            r_wr_count <= '0;
            r_pack     <= '0;
        end else if (w_accept) begin
            // The register keeps only the bytes still waiting for their vector to fill.
            r_pack <= w_packed[VEC_W-9:0];
            if (w_last_byte) begin
                r_byte_cnt <= '0;
                r_wr_count <= r_wr_count + 1'b1;
            end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    // Memory has no reset: a reset mid-load leaves written vectors in place.
    always_ff @(posedge clk) begin
        if (w_accept && w_last_byte) begin
            r_mem[r_wr_count] <= w_packed;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < DEPTH_A) rd_data = r_mem[rd_addr];
    end

    assign in_ready  = (r_state == S_LOAD);
    assign load_busy = (r_state == S_LOAD);
    assign loaded    = (r_state == S_DONE);
    assign wr_count  = r_wr_count;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_nn_test_data_loader.sv
// Randomized bench for nn_test_data_loader against a vector-level memory model.
module tb_nn_test_data_loader;
    localparam int DEPTH = 750;
    localparam int WB    = 62;
    localparam int VW    = 8 * WB;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic [9:0]    rd_addr;
    logic [VW-1:0] rd_data;
    logic          load_busy;
    logic          loaded;
    logic [9:0]    wr_count;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;
    bit abort = 0;
    logic [VW-1:0] exp_mem [DEPTH];

    nn_test_data_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_byte(in_byte),
        .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .load_busy(load_busy), .loaded(loaded),
        .wr_count(wr_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: byte k of vector v is (v+k+base) mod 256, first byte in the top lane.
    function automatic logic [VW-1:0] make_vec(input int v, input int base);
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < WB; k++) r[VW-1-8*k -: 8] = 8'((v + k + base) % 256);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] b, input bit with_start);
        int waited;
        if (abort) return;
        in_valid = 1'b1;
        in_byte  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: in_ready=%0b, required 1", in_ready);
            abort    = 1;
            in_valid = 1'b0;
            return;
        end
        load_start = with_start;
        step();
        in_valid   = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic push_vector(input int v, input int base, input bit gaps);
        for (int k = 0; k < WB; k++) begin
            if (gaps && $urandom_range(7, 0) == 0) idle($urandom_range(3, 1));
            push(8'((v + k + base) % 256), 1'b0);
        end
        exp_mem[v] = make_vec(v, base);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_byte = '0; rd_addr = '0;
        repeat (3) step();
        n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rst_in_ready: got %0b exp 0", in_ready); end
        n_vec++; if (load_busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy: got %0b exp 0", load_busy); end
        n_vec++; if (loaded !== 1'b0)     begin n_err++; $display("FAIL rst_loaded: got %0b exp 0", loaded); end
        n_vec++; if (wr_count !== 10'd0)  begin n_err++; $display("FAIL rst_wr_count: got %0d exp 0", wr_count); end
        rst = 1'b0;
        in_valid = 1'b1; in_byte = 8'hAA;
        step();
        n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL idle_in_ready: got %0b exp 0", in_ready); end
        n_vec++; if (wr_count !== 10'd0)  begin n_err++; $display("FAIL idle_wr_count: got %0d exp 0", wr_count); end
        in_valid = 1'b0;
    endtask

    task automatic test_first_vector_and_async_reset();
        pulse_start();
        n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL start_in_ready: got %0b exp 1", in_ready); end
        n_vec++; if (load_busy !== 1'b1)  begin n_err++; $display("FAIL start_busy: got %0b exp 1", load_busy); end
        n_vec++; if (loaded !== 1'b0)     begin n_err++; $display("FAIL start_loaded: got %0b exp 0", loaded); end
        n_vec++; if (wr_count !== 10'd0)  begin n_err++; $display("FAIL start_wr_count: got %0d exp 0", wr_count); end
        push_vector(0, 1, 1'b0);
        rd_addr = 10'd0;
        #1;
        n_vec++; if (wr_count !== 10'd1)  begin n_err++; $display("FAIL vec0_wr_count: got %0d exp 1", wr_count); end
        n_vec++; if (rd_data !== exp_mem[0]) begin n_err++; $display("FAIL vec0_data: got %h exp %h", rd_data, exp_mem[0]); end
        push_vector(1, 1, 1'b1);
        push_vector(2, 1, 1'b1);
        for (int k = 0; k < 10; k++) push(8'(3 + k + 1), 1'b0);
        n_vec++; if (wr_count !== 10'd3)  begin n_err++; $display("FAIL pre_rst_wr_count: got %0d exp 3", wr_count); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL async_rst_in_ready: got %0b exp 0", in_ready); end
        n_vec++; if (load_busy !== 1'b0)  begin n_err++; $display("FAIL async_rst_busy: got %0b exp 0", load_busy); end
        n_vec++; if (loaded !== 1'b0)     begin n_err++; $display("FAIL async_rst_loaded: got %0b exp 0", loaded); end
        n_vec++; if (wr_count !== 10'd0)  begin n_err++; $display("FAIL async_rst_wr_count: got %0d exp 0", wr_count); end
        for (int a = 0; a < 3; a++) begin
            rd_addr = 10'(a);
            #1;
            n_vec++; if (rd_data !== exp_mem[a]) begin n_err++; $display("FAIL retained_%0d: got %h exp %h", a, rd_data, exp_mem[a]); end
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_load();
        int bytes;
        bytes = 0;
        pulse_start();
        for (int v = 0; v < DEPTH && !abort; v++) begin
            for (int k = 0; k < WB; k++) begin
                if ($urandom_range(7, 0) == 0) idle($urandom_range(3, 1));
                if (v == DEPTH - 1 && k == WB - 1) begin
                    n_vec++; if (loaded !== 1'b0) begin n_err++; $display("FAIL loaded_early: got %0b exp 0", loaded); end
                end
                // A start pulse mid-load must not disturb the transfer.
                push(8'((v + k) % 256), bytes == 100);
                bytes++;
            end
            exp_mem[v] = make_vec(v, 0);
            n_vec++;
            if (wr_count !== 10'(v + 1)) begin n_err++; $display("FAIL load_wr_count_%0d: got %0d exp %0d", v, wr_count, v + 1); end
        end
        n_vec++; if (loaded !== 1'b1)     begin n_err++; $display("FAIL done_loaded: got %0b exp 1", loaded); end
        n_vec++; if (load_busy !== 1'b0)  begin n_err++; $display("FAIL done_busy: got %0b exp 0", load_busy); end
        n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL done_in_ready: got %0b exp 0", in_ready); end
        n_vec++; if (wr_count !== 10'd750) begin n_err++; $display("FAIL done_wr_count: got %0d exp 750", wr_count); end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 10'(a);
            #1;
            n_vec++; if (rd_data !== exp_mem[a]) begin n_err++; $display("FAIL readback_%0d: got %h exp %h", a, rd_data, exp_mem[a]); end
        end
        rd_addr = 10'd750;
        #1;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL oob_750: got %h exp 0", rd_data); end
        rd_addr = 10'd1023;
        #1;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL oob_1023: got %h exp 0", rd_data); end
    endtask

    task automatic test_done_hold_and_reload();
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready_%0d: got %0b exp 0", c, in_ready); end
            step();
        end
        in_valid = 1'b0;
        n_vec++; if (wr_count !== 10'd750) begin n_err++; $display("FAIL hold_wr_count: got %0d exp 750", wr_count); end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 10'(a);
            #1;
            n_vec++; if (rd_data !== exp_mem[a]) begin n_err++; $display("FAIL hold_mem_%0d: got %h exp %h", a, rd_data, exp_mem[a]); end
        end
        pulse_start();
        n_vec++; if (loaded !== 1'b0)     begin n_err++; $display("FAIL reload_loaded: got %0b exp 0", loaded); end
        n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reload_in_ready: got %0b exp 1", in_ready); end
        n_vec++; if (wr_count !== 10'd0)  begin n_err++; $display("FAIL reload_wr_count: got %0d exp 0", wr_count); end
        push_vector(0, 8'h80, 1'b1);
        rd_addr = 10'd0;
        #1;
        n_vec++; if (rd_data !== exp_mem[0]) begin n_err++; $display("FAIL reload_vec0: got %h exp %h", rd_data, exp_mem[0]); end
        rd_addr = 10'd1;
        #1;
        n_vec++; if (rd_data !== exp_mem[1]) begin n_err++; $display("FAIL reload_vec1_kept: got %h exp %h", rd_data, exp_mem[1]); end
        n_vec++; if (wr_count !== 10'd1)  begin n_err++; $display("FAIL reload_wr_count_1: got %0d exp 1", wr_count); end
    endtask

    initial begin
        test_reset();
        test_first_vector_and_async_reset();
        test_full_load();
        test_done_hold_and_reload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
